// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the fetch / load-store memory bus arbiter.
// FSM encodings are plain localparams so older code comparing raw values keeps working.
package mem_bus_arbiter_pkg;

    localparam int                RegBus    = 32;
    localparam logic [RegBus-1:0] ZeroWord  = '0;
    localparam logic              RstEnable = 1'b1;
    localparam logic [3:0]        BusSelAll = 4'b1111;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ArbIdle    = 2'd0;
    localparam arb_state_t ArbBusyIf  = 2'd1;
    localparam arb_state_t ArbBusyMem = 2'd2;
    localparam arb_state_t ArbAck     = 2'd3;

    typedef struct packed {
        logic              we;
        logic [RegBus-1:0] addr;
        logic [RegBus-1:0] wdata;
        logic [3:0]        sel;
    } bus_req_t;

    // Fetches are always full-word reads with no write data.
    function automatic bus_req_t fetch_req(input logic [RegBus-1:0] addr);
        bus_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = ZeroWord;
        r.sel   = BusSelAll;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout_counter.sv
// Watchdog counter for a bus cycle: counts enabled cycles since the last clear and
// flags the cycle in which the LIMIT-th enabled cycle without completion occurs.
module bus_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store, mem first.
// Define BUS_TIMEOUT_EN to abort a bus cycle that sees no bus_ack_i within TIMEOUT_CYCLES.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [RegBus-1:0] if_addr_i,
    output logic [RegBus-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              flush_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [RegBus-1:0] mem_addr_i,
    input  logic [RegBus-1:0] mem_wdata_i,
    input  logic [3:0]        mem_sel_i,
    output logic [RegBus-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_cyc_o,
    output logic              bus_we_o,
    output logic [RegBus-1:0] bus_addr_o,
    output logic [RegBus-1:0] bus_wdata_o,
    output logic [3:0]        bus_sel_o,
    input  logic [RegBus-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);
    arb_state_t        state_reg, state_next;
    bus_req_t          bus_req_reg;
    bus_req_t          mem_req;
    logic              bus_cyc_reg;
    logic              grant_mem_reg;
    logic              flush_flag_reg;
    logic [RegBus-1:0] if_rdata_reg;
    logic [RegBus-1:0] mem_rdata_reg;
    logic              busy;
    logic              in_ack;
    logic              timeout_hit;
    logic              access_done;
    logic [RegBus-1:0] capture_data;

    assign busy         = (state_reg == ArbBusyIf) || (state_reg == ArbBusyMem);
    assign in_ack       = (state_reg == ArbAck);
    assign access_done  = busy && (bus_ack_i || timeout_hit);
    // A watchdog abort hands back zero rather than whatever is floating on the bus.
    assign capture_data = bus_ack_i ? bus_rdata_i : ZeroWord;

    assign mem_req.we    = mem_we_i;
    assign mem_req.addr  = mem_addr_i;
    assign mem_req.wdata = mem_wdata_i;
    assign mem_req.sel   = mem_sel_i;

`ifdef BUS_TIMEOUT_EN
    logic err_reg;

    bus_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg == ArbIdle),
        .enable (busy),
        .expired(timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= busy && timeout_hit && !bus_ack_i;
        end
    end

    assign bus_err_o = err_reg;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign bus_err_o          = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ArbIdle: begin
                if (mem_req_i) begin
                    state_next = ArbBusyMem;
                end else if (if_req_i && !flush_i) begin
                    state_next = ArbBusyIf;
                end
            end
            ArbBusyIf, ArbBusyMem: begin
                if (access_done) begin
                    state_next = ArbAck;
                end
            end
            // The ACK state never re-arbitrates, so a request still held there is not reissued.
            default: state_next = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_reg      <= ArbIdle;
            bus_req_reg    <= '0;
            bus_cyc_reg    <= 1'b0;
            grant_mem_reg  <= 1'b0;
            flush_flag_reg <= 1'b0;
            if_rdata_reg   <= ZeroWord;
            mem_rdata_reg  <= ZeroWord;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ArbIdle: begin
                    flush_flag_reg <= 1'b0;
                    if (mem_req_i) begin
                        grant_mem_reg <= 1'b1;
                        bus_cyc_reg   <= 1'b1;
                        bus_req_reg   <= mem_req;
                    end else if (if_req_i && !flush_i) begin
                        grant_mem_reg <= 1'b0;
                        bus_cyc_reg   <= 1'b1;
                        bus_req_reg   <= fetch_req(if_addr_i);
                    end
                end
                ArbBusyIf, ArbBusyMem: begin
                    // The fetch cycle still runs to completion; only its ack is withheld.
                    if ((state_reg == ArbBusyIf) && flush_i) begin
                        flush_flag_reg <= 1'b1;
                    end
                    if (access_done) begin
                        bus_cyc_reg <= 1'b0;
                        if (grant_mem_reg) begin
                            mem_rdata_reg <= bus_req_reg.we ? ZeroWord : capture_data;
                        end else begin
                            if_rdata_reg <= capture_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_ack_o  = in_ack && !grant_mem_reg && !flush_flag_reg && !flush_i;
    assign mem_ack_o = in_ack && grant_mem_reg;

    assign if_rdata_o  = if_rdata_reg;
    assign mem_rdata_o = mem_rdata_reg;

    assign bus_cyc_o   = bus_cyc_reg;
    assign bus_we_o    = bus_req_reg.we;
    assign bus_addr_o  = bus_req_reg.addr;
    assign bus_wdata_o = bus_req_reg.wdata;
    assign bus_sel_o   = bus_req_reg.sel;

    assign stallreq_if_o  = if_req_i && !if_ack_o;
    assign stallreq_mem_o = mem_req_i && !mem_ack_o;

endmodule
